corr_pkt_rx: RTL and testbench
==============================

CORR_PKT_RX -- requirements
Module: corr_pkt_rx

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255: max idle cycles between accepted bytes inside a packet; legal range 1..65535.
REQ-002 SHALL have parameter PKT_BYTES, default 5: fixed packet length; byte 0 is winNum, bytes 1..4 are countX, countY, countIsect, countSymdiff.
REQ-003 SHALL have port i_clk, input, 1, sole clock.
REQ-004 SHALL have port i_rst, input, 1, reset, asynchronous and active-high.
REQ-005 SHALL have port i_cg, input, 1, clock-gate enable; when 0, no state changes.
REQ-006 SHALL have port i_flush, input, 1, discard partial packet and forget winNum history.
REQ-007 SHALL have ports i_bp_data, input, 8, and i_bp_valid, input, 1: BytePipe byte stream in.
REQ-008 SHALL have port o_bp_ready, output, 1, BytePipe ready.
REQ-009 SHALL have port o_pkt_data, output, 40, assembled packet {symdiff, isect, y, x, winNum} with winNum in bits [7:0].
REQ-010 SHALL have ports o_pkt_valid, output, 1, and i_pkt_ready, input, 1: packet valid/ready handshake.
REQ-011 SHALL have port o_nDropped, output, 8, saturating count of missing windows.
REQ-012 SHALL have port o_nTimeouts, output, 8, saturating count of abandoned partial packets.
REQ-013 SHALL have port o_nPkts, output, 16, wrapping count of delivered packets.

Function
REQ-014 Byte transfer SHALL occur on a cycle with i_cg && i_bp_valid && o_bp_ready.
REQ-015 FSM states SHALL be HEAD (await byte 0), BODY (await bytes 1..PKT_BYTES-1) and HOLD (packet presented).
REQ-016 HEAD->BODY SHALL occur on a transfer; byte index SHALL become 1.
REQ-017 BODY SHALL stay in BODY until the byte with index PKT_BYTES-1 transfers, then go to HOLD on the next edge.
REQ-018 o_bp_ready SHALL be 1 in HEAD/BODY and 0 in HOLD, with no combinational path from i_pkt_ready.
REQ-019 o_pkt_valid SHALL be 1 exactly in HOLD; latency SHALL be 1 cycle from the final byte transfer to o_pkt_valid=1.
REQ-020 o_pkt_data SHALL be stable while o_pkt_valid=1.
REQ-021 HOLD->HEAD SHALL occur when i_pkt_ready=1 (with i_cg); o_nPkts SHALL increment, wrapping 0xFFFF->0.
REQ-022 Idle counter SHALL clear on every transfer and increment each BODY cycle without a transfer.
REQ-023 When the idle counter reaches TIMEOUT_CYCLES in BODY: go to HEAD, discard partial bytes, increment o_nTimeouts saturating at 255; winNum history SHALL be unchanged.
REQ-024 winNum history SHALL be a valid flag plus the last delivered winNum.
REQ-025 On entry to HOLD with history valid: gap = (winNum - last - 1) mod 256; o_nDropped += gap, saturating at 255.
REQ-026 On entry to HOLD with history invalid: no count; history SHALL become valid.
REQ-027 The gap update SHALL happen once per packet, at HOLD entry.
REQ-028 i_flush (with i_cg) SHALL force HEAD, clear the byte index, idle counter and history-valid flag; it SHALL drop a packet held in HOLD without incrementing o_nPkts; counters SHALL be unaffected.
REQ-029 i_flush SHALL take priority over a simultaneous transfer, timeout or pkt handshake; the flush-cycle byte SHALL be discarded.
REQ-030 A transfer and a timeout in the same cycle SHALL be treated as the transfer (no timeout).

Reset
REQ-031 During i_rst: state HEAD, byte index 0, idle counter 0, history invalid, o_pkt_valid=0, o_pkt_data=0, o_nDropped=0, o_nTimeouts=0, o_nPkts=0, o_bp_ready=1.
REQ-032 Reset asserted mid-packet or in HOLD SHALL take effect immediately (asynchronously), independent of i_cg.

Verification
REQ-033 Bytes 07,11,22,33,44 back-to-back, i_pkt_ready=1 -> o_pkt_valid the cycle after 0x44, o_pkt_data=0x4433221107, o_nPkts=1, o_nDropped=0.
REQ-034 Packets with winNum FE then 02 -> o_nDropped=3; packets with winNum 00 then 00 (gap 255) -> o_nDropped saturates at 255.
REQ-035 3 bytes, then valid low for TIMEOUT_CYCLES cycles -> o_nTimeouts=1, state HEAD; next 5 bytes deliver a packet whose winNum is the first of those bytes.
REQ-036 i_pkt_ready=0 for 10 cycles after packet complete -> o_bp_ready=0 and o_pkt_data stable throughout; i_pkt_ready=1 -> HEAD next cycle.
REQ-037 i_flush in HOLD and in the same cycle as a byte transfer -> no packet delivered, o_nPkts unchanged; the next packet does not update o_nDropped.
REQ-038 Async i_rst mid-BODY with i_cg=0 -> all outputs reach reset values without a clock edge.

Source files
------------

// File: rtl/corr_pkt_rx.sv
// Correlator packet receiver: assembles fixed-length packets from a BytePipe byte stream,
// presents them on a valid/ready port and keeps drop, timeout and packet statistics.
module corr_pkt_rx #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int PKT_BYTES      = 5
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_cg,
    input  logic        i_flush,
    input  logic [7:0]  i_bp_data,
    input  logic        i_bp_valid,
    output logic        o_bp_ready,
    output logic [39:0] o_pkt_data,
    output logic        o_pkt_valid,
    input  logic        i_pkt_ready,
    output logic [7:0]  o_nDropped,
    output logic [7:0]  o_nTimeouts,
    output logic [15:0] o_nPkts
);

    localparam int IDX_W = (PKT_BYTES > 2) ? $clog2(PKT_BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PKT_BYTES - 1);
    localparam logic [16:0] TIMEOUT_LIMIT = 17'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {HEAD, BODY, HOLD} rxState;

    rxState           state;
    rxState           nextState;
    logic [IDX_W-1:0] byteIdx;
    logic [15:0]      idleCnt;
    logic             histValid;
    logic [7:0]       lastWin;
    logic [39:0]      pktReg;
    logic [7:0]       dropCnt;
    logic [7:0]       timeoutCnt;
    logic [15:0]      pktCnt;
    logic             accept;
    logic             idleReached;
    logic [7:0]       gap;
    logic [8:0]       dropSum;

    assign accept      = i_bp_valid && (state != HOLD);
    assign idleReached = ({1'b0, idleCnt} + 17'd1) == TIMEOUT_LIMIT;
    assign gap         = pktReg[7:0] - lastWin - 8'd1;
    assign dropSum     = {1'b0, dropCnt} + {1'b0, gap};

    assign o_bp_ready  = (state != HOLD);
    assign o_pkt_valid = (state == HOLD);
    assign o_pkt_data  = pktReg;
    assign o_nDropped  = dropCnt;
    assign o_nTimeouts = timeoutCnt;
    assign o_nPkts     = pktCnt;

    // Next state: a transfer beats a timeout; flush beats everything.
    always_comb begin
        nextState = state;
        case (state)
            HEAD: if (accept) nextState = BODY;
            BODY: begin
                if (accept) begin
                    if (byteIdx == LAST_IDX) nextState = HOLD;
                end else if (idleReached) begin
                    nextState = HEAD;
                end
            end
            HOLD: if (i_pkt_ready) nextState = HEAD;
            default: nextState = HEAD;
        endcase
        if (i_flush) nextState = HEAD;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= HEAD;
            byteIdx    <= '0;
            idleCnt    <= '0;
            histValid  <= 1'b0;
            lastWin    <= '0;
            pktReg     <= '0;
            dropCnt    <= '0;
            timeoutCnt <= '0;
            pktCnt     <= '0;
        end else if (i_cg) begin
            state <= nextState;
            if (i_flush) begin
                byteIdx   <= '0;
                idleCnt   <= '0;
                histValid <= 1'b0;
            end else begin
                if (accept) begin
                    for (int b = 0; b < 5; b++) begin
                        if (int'(byteIdx) == b) pktReg[8*b +: 8] <= i_bp_data;
                    end
                    idleCnt <= '0;
                end
                case (state)
                    HEAD: if (accept) byteIdx <= IDX_W'(1);
                    BODY: begin
                        if (accept) begin
                            if (byteIdx == LAST_IDX) begin
                                // Window-gap accounting happens once, as the packet enters HOLD.
                                byteIdx   <= '0;
                                histValid <= 1'b1;
                                lastWin   <= pktReg[7:0];
                                if (histValid) dropCnt <= dropSum[8] ? 8'hFF : dropSum[7:0];
                            end else begin
                                byteIdx <= byteIdx + IDX_W'(1);
                            end
                        end else if (idleReached) begin
                            byteIdx <= '0;
                            idleCnt <= '0;
                            if (timeoutCnt != 8'hFF) timeoutCnt <= timeoutCnt + 8'd1;
                        end else begin
                            idleCnt <= idleCnt + 16'd1;
                        end
                    end
                    HOLD: if (i_pkt_ready) pktCnt <= pktCnt + 16'd1;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_corr_pkt_rx.sv
// Self-checking bench for corr_pkt_rx: scoreboard of expected packets plus per-scenario checks
// of handshake timing, drop/timeout/packet counters, flush and asynchronous reset.
module tb_corr_pkt_rx;

    localparam int TIMEOUT = 20;

    logic        clk = 1'b0;
    logic        rst, cg, flush, bpValid, pktReady;
    logic [7:0]  bpData;
    logic        bpReady, pktValid;
    logic [39:0] pktData;
    logic [7:0]  nDropped, nTimeouts;
    logic [15:0] nPkts;

    int testsRun = 0;
    int testsFailed = 0;
    logic [39:0] expQ[$];
    logic [39:0] monExp;

    bit         mValid;
    logic [7:0] mLast;
    int         mDropped;
    int         expPkts;

    corr_pkt_rx #(.TIMEOUT_CYCLES(TIMEOUT), .PKT_BYTES(5)) dut (
        .i_clk(clk), .i_rst(rst), .i_cg(cg), .i_flush(flush),
        .i_bp_data(bpData), .i_bp_valid(bpValid), .o_bp_ready(bpReady),
        .o_pkt_data(pktData), .o_pkt_valid(pktValid), .i_pkt_ready(pktReady),
        .o_nDropped(nDropped), .o_nTimeouts(nTimeouts), .o_nPkts(nPkts)
    );

    always #5 clk = ~clk;

    // Scoreboard: every handshake the DUT is about to complete must match the oldest expected packet.
    always @(negedge clk) begin
        if (!rst && cg && !flush && pktValid && pktReady) begin
            testsRun++;
            if (expQ.size() == 0) begin
                testsFailed++;
                $display("[TB] FAIL scoreboard: unexpected packet %h, required none", pktData);
            end else begin
                monExp = expQ.pop_front();
                if (pktData !== monExp) begin
                    testsFailed++;
                    $display("[TB] FAIL scoreboard: packet %h, required %h", pktData, monExp);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic void holdEntry(input logic [7:0] win);
        int g;
        if (mValid) begin
            g = (int'(win) - int'(mLast) + 255) % 256;
            mDropped = (mDropped + g > 255) ? 255 : mDropped + g;
        end
        mValid = 1'b1;
        mLast  = win;
    endfunction

    task automatic sendByte(input logic [7:0] b);
        bpData  = b;
        bpValid = 1'b1;
        @(posedge clk); #1;
        bpValid = 1'b0;
    endtask

    task automatic sendPacket(input logic [39:0] pkt, input bit push);
        for (int i = 0; i < 5; i++) begin
            bpData  = pkt[8*i +: 8];
            bpValid = 1'b1;
            @(posedge clk); #1;
        end
        bpValid = 1'b0;
        holdEntry(pkt[7:0]);
        if (push) expQ.push_back(pkt);
    endtask

    task automatic deliverPacket(input logic [39:0] pkt);
        sendPacket(pkt, 1'b1);
        @(posedge clk); #1;
        expPkts++;
    endtask

    task automatic resetDut();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        mValid = 1'b0; mLast = '0; mDropped = 0; expPkts = 0;
        expQ.delete();
    endtask

    function automatic logic [39:0] mkPkt(input logic [7:0] win);
        return {win ^ 8'h5A, win + 8'd3, 8'h22, 8'h11, win};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        #1;
        testsRun += 6;
        if (pktValid !== 1'b0)     begin testsFailed++; $display("[TB] FAIL reset_valid: %b, required 0", pktValid); end
        if (pktData !== 40'h0)     begin testsFailed++; $display("[TB] FAIL reset_data: %h, required 0", pktData); end
        if (nDropped !== 8'h0)     begin testsFailed++; $display("[TB] FAIL reset_dropped: %0d, required 0", nDropped); end
        if (nTimeouts !== 8'h0)    begin testsFailed++; $display("[TB] FAIL reset_timeouts: %0d, required 0", nTimeouts); end
        if (nPkts !== 16'h0)       begin testsFailed++; $display("[TB] FAIL reset_pkts: %0d, required 0", nPkts); end
        if (bpReady !== 1'b1)      begin testsFailed++; $display("[TB] FAIL reset_ready: %b, required 1", bpReady); end
        @(posedge clk); #1;
        rst = 1'b0;
        mValid = 1'b0; mDropped = 0; expPkts = 0;
    endtask

    task automatic test_basic();
        sendPacket(40'h4433221107, 1'b1);
        testsRun += 3;
        if (pktValid !== 1'b1)         begin testsFailed++; $display("[TB] FAIL basic_latency: valid %b, required 1", pktValid); end
        if (pktData !== 40'h4433221107) begin testsFailed++; $display("[TB] FAIL basic_data: %h, required 4433221107", pktData); end
        if (bpReady !== 1'b0)          begin testsFailed++; $display("[TB] FAIL basic_ready: %b, required 0", bpReady); end
        @(posedge clk); #1;
        expPkts++;
        testsRun += 3;
        if (nPkts !== 16'd1)     begin testsFailed++; $display("[TB] FAIL basic_pkts: %0d, required 1", nPkts); end
        if (nDropped !== 8'd0)   begin testsFailed++; $display("[TB] FAIL basic_dropped: %0d, required 0", nDropped); end
        if (pktValid !== 1'b0)   begin testsFailed++; $display("[TB] FAIL basic_release: valid %b, required 0", pktValid); end
    endtask

    task automatic test_gap();
        logic [7:0] wins [7] = '{8'h00, 8'h00, 8'hFE, 8'h02, 8'h03, 8'h05, 8'h04};
        int         drops[7] = '{0, 255, 0, 3, 3, 4, 255};
        for (int i = 0; i < 7; i++) begin
            if (i == 0 || i == 2) resetDut();
            deliverPacket(mkPkt(wins[i]));
            testsRun++;
            if (nDropped !== 8'(drops[i])) begin
                testsFailed++;
                $display("[TB] FAIL gap_%0d: dropped %0d, required %0d", i, nDropped, drops[i]);
            end
        end
    endtask

    task automatic test_timeout();
        resetDut();
        deliverPacket(mkPkt(8'h10));
        sendByte(8'h20); sendByte(8'h01); sendByte(8'h02);
        repeat (TIMEOUT - 1) @(posedge clk);
        #1;
        testsRun++;
        if (nTimeouts !== 8'd0) begin testsFailed++; $display("[TB] FAIL timeout_early: %0d, required 0", nTimeouts); end
        @(posedge clk); #1;
        testsRun += 2;
        if (nTimeouts !== 8'd1) begin testsFailed++; $display("[TB] FAIL timeout_count: %0d, required 1", nTimeouts); end
        if (bpReady !== 1'b1)   begin testsFailed++; $display("[TB] FAIL timeout_ready: %b, required 1", bpReady); end
        deliverPacket(mkPkt(8'h13));
        testsRun++;
        if (nDropped !== 8'd2) begin testsFailed++; $display("[TB] FAIL timeout_history: dropped %0d, required 2", nDropped); end
        // Final idle cycle coincides with a transfer: must not count as a timeout.
        sendByte(8'h14); sendByte(8'h55); sendByte(8'h66);
        repeat (TIMEOUT - 1) @(posedge clk);
        #1;
        sendByte(8'h77); sendByte(8'h88);
        holdEntry(8'h14);
        expQ.push_back(40'h8877665514);
        @(posedge clk); #1;
        expPkts++;
        testsRun += 2;
        if (nTimeouts !== 8'd1) begin testsFailed++; $display("[TB] FAIL timeout_vs_xfer: %0d, required 1", nTimeouts); end
        if (nDropped !== 8'd2)  begin testsFailed++; $display("[TB] FAIL timeout_vs_xfer_drop: %0d, required 2", nDropped); end
    endtask

    task automatic test_hold();
        logic [39:0] pkt = 40'hCAFE123415;
        pktReady = 1'b0;
        sendPacket(pkt, 1'b1);
        for (int i = 0; i < 10; i++) begin
            testsRun++;
            if ({pktValid, bpReady, pktData} !== {1'b1, 1'b0, pkt}) begin
                testsFailed++;
                $display("[TB] FAIL hold_%0d: valid %b ready %b data %h, required 1 0 %h", i, pktValid, bpReady, pktData, pkt);
            end
            bpData  = 8'(i) ^ 8'hA5;
            bpValid = 1'b1;
            @(posedge clk); #1;
        end
        bpValid  = 1'b0;
        pktReady = 1'b1;
        @(posedge clk); #1;
        expPkts++;
        testsRun += 2;
        if ({pktValid, bpReady} !== 2'b01) begin testsFailed++; $display("[TB] FAIL hold_release: valid %b ready %b, required 0 1", pktValid, bpReady); end
        if (nPkts !== 16'(expPkts))        begin testsFailed++; $display("[TB] FAIL hold_pkts: %0d, required %0d", nPkts, expPkts); end
    endtask

    task automatic test_flush();
        pktReady = 1'b0;
        sendPacket(mkPkt(8'h20), 1'b0);
        flush = 1'b1; pktReady = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; mValid = 1'b0;
        testsRun += 3;
        if (pktValid !== 1'b0)              begin testsFailed++; $display("[TB] FAIL flush_hold: valid %b, required 0", pktValid); end
        if (nPkts !== 16'(expPkts))         begin testsFailed++; $display("[TB] FAIL flush_pkts: %0d, required %0d", nPkts, expPkts); end
        if (nDropped !== 8'(mDropped))      begin testsFailed++; $display("[TB] FAIL flush_hold_drop: %0d, required %0d", nDropped, mDropped); end
        sendByte(8'h30); sendByte(8'h31);
        bpData = 8'hAA; bpValid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        bpValid = 1'b0; flush = 1'b0;
        deliverPacket(mkPkt(8'h50));
        testsRun += 2;
        if (nDropped !== 8'(mDropped)) begin testsFailed++; $display("[TB] FAIL flush_history: dropped %0d, required %0d", nDropped, mDropped); end
        if (nPkts !== 16'(expPkts))    begin testsFailed++; $display("[TB] FAIL flush_after_pkts: %0d, required %0d", nPkts, expPkts); end
    endtask

    task automatic test_clock_gate();
        cg = 1'b0;
        for (int i = 0; i < 5; i++) sendByte(8'hE0 + 8'(i));
        testsRun++;
        if (pktValid !== 1'b0) begin testsFailed++; $display("[TB] FAIL gate_valid: %b, required 0", pktValid); end
        cg = 1'b1;
        deliverPacket(mkPkt(8'h51));
        testsRun++;
        if (nPkts !== 16'(expPkts)) begin testsFailed++; $display("[TB] FAIL gate_pkts: %0d, required %0d", nPkts, expPkts); end
    endtask

    task automatic test_async_reset();
        sendByte(8'h60); sendByte(8'h61);
        cg = 1'b0;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        testsRun += 6;
        if (pktValid !== 1'b0)  begin testsFailed++; $display("[TB] FAIL async_valid: %b, required 0", pktValid); end
        if (pktData !== 40'h0)  begin testsFailed++; $display("[TB] FAIL async_data: %h, required 0", pktData); end
        if (nDropped !== 8'h0)  begin testsFailed++; $display("[TB] FAIL async_dropped: %0d, required 0", nDropped); end
        if (nTimeouts !== 8'h0) begin testsFailed++; $display("[TB] FAIL async_timeouts: %0d, required 0", nTimeouts); end
        if (nPkts !== 16'h0)    begin testsFailed++; $display("[TB] FAIL async_pkts: %0d, required 0", nPkts); end
        if (bpReady !== 1'b1)   begin testsFailed++; $display("[TB] FAIL async_ready: %b, required 1", bpReady); end
        @(posedge clk); #1;
        rst = 1'b0; cg = 1'b1;
        mValid = 1'b0; mDropped = 0; expPkts = 0;
        deliverPacket(mkPkt(8'h70));
        testsRun += 2;
        if (nPkts !== 16'd1)   begin testsFailed++; $display("[TB] FAIL async_restart_pkts: %0d, required 1", nPkts); end
        if (nDropped !== 8'd0) begin testsFailed++; $display("[TB] FAIL async_restart_drop: %0d, required 0", nDropped); end
    endtask

    initial begin
        rst = 1'b1; cg = 1'b1; flush = 1'b0; bpValid = 1'b0; bpData = '0; pktReady = 1'b1;
        mValid = 1'b0; mLast = '0; mDropped = 0; expPkts = 0;
        #2;
        test_reset();
        test_basic();
        test_gap();
        test_timeout();
        test_hold();
        test_flush();
        test_clock_gate();
        test_async_reset();
        repeat (2) @(posedge clk);
        #1;
        testsRun++;
        if (expQ.size() != 0) begin
            testsFailed++;
            $display("[TB] FAIL scoreboard_drain: %0d packets outstanding, required 0", expQ.size());
        end
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
